// File: rtl/priority_encoder_rr.sv
// N-input request arbiter: fixed-priority or round-robin winner selection with a
// registered, sticky grant that is held until the consumer acks it.
module priority_encoder_rr #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [N-1:0]         req,
  input  logic                 ack,
  output logic [$clog2(N)-1:0] out,
  output logic [N-1:0]         grant,
  output logic                 valid
);

  localparam int OUT_W = $clog2(N);
  localparam logic [OUT_W-1:0] LAST = OUT_W'(N - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] ptr_q, ptr_d;
  logic             mode_q, mode_d;   // mode the held grant was captured in
  logic [N-1:0]     grant_q, grant_d;

  logic             capture;
  logic [OUT_W-1:0] start;
  logic [OUT_W-1:0] win;
  logic             found;
  logic [OUT_W-1:0] idx_w;
  int               idx;

  // An ack of an RR-captured grant moves ptr; a same-edge capture must see the new value.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == HOLD && ack && mode_q)
      ptr_d = (out_q == '0) ? LAST : out_q - OUT_W'(1);
  end

  assign start   = mode ? ptr_d : LAST;
  assign capture = en && (|req) && (state_q == IDLE || ack);

  // Downward scan from start, wrapping modulo N (valid for non-power-of-2 N).
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) - k;
      if (idx < 0) idx = idx + N;
      idx_w = OUT_W'(idx);
      if (!found && req[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = HOLD;
          out_d   = win;
          mode_d  = mode;
        end
      end
      HOLD: begin
        if (ack) begin
          if (capture) begin
            out_d  = win;
            mode_d = mode;
          end else begin
            state_d = IDLE;
            out_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign grant_d[i] = (state_d == HOLD) && (out_d == OUT_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      ptr_q   <= LAST;
      mode_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      grant_q <= grant_d;
    end
  end

  assign out   = out_q;
  assign grant = grant_q;
  assign valid = (state_q == HOLD);

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed bench for priority_encoder_rr: N=8 and N=5 instances, hand-computed expectations.
module tb_priority_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       en_a = 1'b0, mode_a = 1'b0, ack_a = 1'b0;
  logic [7:0] req_a = '0;
  logic [2:0] out_a;
  logic [7:0] grant_a;
  logic       valid_a;

  logic       en_b = 1'b0, mode_b = 1'b0, ack_b = 1'b0;
  logic [4:0] req_b = '0;
  logic [2:0] out_b;
  logic [4:0] grant_b;
  logic       valid_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  priority_encoder_rr #(.N(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .req(req_a), .ack(ack_a),
    .out(out_a), .grant(grant_a), .valid(valid_a)
  );

  priority_encoder_rr #(.N(5)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .req(req_b), .ack(ack_b),
    .out(out_b), .grant(grant_b), .valid(valid_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [2:0] o, input logic [7:0] g);
    chk({tag, ".valid"}, 32'(valid_a), 32'(v));
    chk({tag, ".out"},   32'(out_a),   32'(o));
    chk({tag, ".grant"}, 32'(grant_a), 32'(g));
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [2:0] o, input logic [4:0] g);
    chk({tag, ".valid"}, 32'(valid_b), 32'(v));
    chk({tag, ".out"},   32'(out_b),   32'(o));
    chk({tag, ".grant"}, 32'(grant_b), 32'(g));
  endtask

  initial begin
    logic [2:0] rr_seq [9];
    rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    // Reset state, then reach HOLD with out=5 and reset asynchronously mid-HOLD
    #12;
    chk_a("rst0", 1'b0, 3'd0, 8'h00);
    chk_b("rst0b", 1'b0, 3'd0, 5'h00);
    rst_n = 1'b1;
    en_a = 1'b1; req_a = 8'h20;
    step();
    chk_a("hold5", 1'b1, 3'd5, 8'h20);
    rst_n = 1'b0;
    #2;
    chk_a("async_rst", 1'b0, 3'd0, 8'h00);
    #2;
    rst_n = 1'b1;
    req_a = 8'h01;
    step();
    chk_a("post_rst", 1'b1, 3'd0, 8'h01);
    ack_a = 1'b1; en_a = 1'b0; req_a = 8'h00;
    step();
    chk_a("drain1", 1'b0, 3'd0, 8'h00);

    // Fixed mode, sticky hold, back-to-back on ack
    ack_a = 1'b0; en_a = 1'b1; mode_a = 1'b0; req_a = 8'b1000_0101;
    step();
    chk_a("fix7", 1'b1, 3'd7, 8'h80);
    req_a = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("fix_hold", 1'b1, 3'd7, 8'h80);
    end
    req_a = 8'b1000_0101; ack_a = 1'b1;
    step();
    chk_a("fix_b2b", 1'b1, 3'd7, 8'h80);
    en_a = 1'b0;
    step();
    chk_a("fix_drain", 1'b0, 3'd0, 8'h00);

    // Enable gating
    ack_a = 1'b0; req_a = 8'h44;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("en_off", 1'b0, 3'd0, 8'h00);
    end
    en_a = 1'b1;
    step();
    chk_a("en_on", 1'b1, 3'd6, 8'h40);
    ack_a = 1'b1; en_a = 1'b0;
    step();
    chk_a("en_drain", 1'b0, 3'd0, 8'h00);

    // Round-robin over all requests: 7..0 then wrap to 7
    mode_a = 1'b1; en_a = 1'b1; req_a = 8'hFF; ack_a = 1'b0;
    step();
    chk_a("rr_all0", 1'b1, rr_seq[0], 8'h80);
    ack_a = 1'b1;
    for (int i = 1; i < 9; i++) begin
      step();
      chk_a("rr_all", 1'b1, rr_seq[i], 8'(8'h01 << rr_seq[i]));
    end
    // Ack of 7 captured in RR leaves ptr=6
    en_a = 1'b0;
    step();
    chk_a("rr_drain", 1'b0, 3'd0, 8'h00);

    // RR with two requests alternates, then fixed mode sticks on 5
    en_a = 1'b1; req_a = 8'b0010_0100; ack_a = 1'b0;
    step();
    chk_a("rr2_0", 1'b1, 3'd5, 8'h20);
    ack_a = 1'b1;
    step();
    chk_a("rr2_1", 1'b1, 3'd2, 8'h04);
    step();
    chk_a("rr2_2", 1'b1, 3'd5, 8'h20);
    step();
    chk_a("rr2_3", 1'b1, 3'd2, 8'h04);
    mode_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("fix_after_rr", 1'b1, 3'd5, 8'h20);
    end

    // Sticky through req=0, then drain to IDLE with en=1 and req=0
    en_a = 1'b0;
    step();
    chk_a("pre6", 1'b0, 3'd0, 8'h00);
    en_a = 1'b1; ack_a = 1'b0; req_a = 8'h08;
    step();
    chk_a("cap3", 1'b1, 3'd3, 8'h08);
    req_a = 8'h00;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_a("sticky3", 1'b1, 3'd3, 8'h08);
    end
    ack_a = 1'b1;
    step();
    chk_a("req0_idle", 1'b0, 3'd0, 8'h00);
    step();
    chk_a("req0_stay", 1'b0, 3'd0, 8'h00);

    // N=5 round-robin wraps without exceeding index 4
    en_b = 1'b1; mode_b = 1'b1; req_b = 5'b10001; ack_b = 1'b0;
    step();
    chk_b("n5_0", 1'b1, 3'd4, 5'h10);
    ack_b = 1'b1;
    step();
    chk_b("n5_1", 1'b1, 3'd0, 5'h01);
    step();
    chk_b("n5_2", 1'b1, 3'd4, 5'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
